regfile_wb_arbiter: RTL and testbench

//  Writer side of the CPU register file: owns the single write port (we/waddr/wdata).

---
 rtl/regfile_wb_arbiter.sv | 136 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: merges in-order pipeline writebacks with buffered
// long-latency results, and tracks pending destinations of in-flight long ops.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_p_valid,
  input  logic [ADDR_W-1:0] i_p_addr,
  input  logic [DATA_W-1:0] i_p_data,
  output logic              o_p_ready,
  input  logic              i_l_valid,
  input  logic [ADDR_W-1:0] i_l_addr,
  input  logic [DATA_W-1:0] i_l_data,
  output logic              o_l_ready,
  input  logic              i_iss_valid,
  input  logic [ADDR_W-1:0] i_iss_addr,
  input  logic [ADDR_W-1:0] i_chk_addr1,
  input  logic [ADDR_W-1:0] i_chk_addr2,
  output logic              o_busy1,
  output logic              o_busy2,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ST_W  = $clog2(STARVE_LIM + 1);
  localparam int unsigned NREG  = 2 ** ADDR_W;

  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [ST_W-1:0]   r_starve;
  logic [NREG-1:0]   r_pending;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_empty, w_full, w_force, w_p_win, w_l_win, w_push, w_write;
  logic [ADDR_W-1:0] w_head_addr, w_win_addr;
  logic [DATA_W-1:0] w_head_data, w_win_data;
  logic [CNT_W-1:0]  w_count_d;
  logic [ST_W-1:0]   w_starve_d;
  logic [NREG-1:0]   w_pending_d;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_force     = !w_empty && (r_starve == ST_W'(STARVE_LIM));
  assign w_p_win     = i_p_valid && !w_force;
  assign w_l_win     = !w_p_win && !w_empty;
  assign w_push      = i_l_valid && !w_full;
  assign w_head_addr = r_fifo_addr[r_rptr];
  assign w_head_data = r_fifo_data[r_rptr];
  assign w_win_addr  = w_p_win ? i_p_addr : w_head_addr;
  assign w_win_data  = w_p_win ? i_p_data : w_head_data;
  assign w_write     = (w_p_win || w_l_win) && (w_win_addr != '0);

  assign o_p_ready = w_p_win;
  assign o_l_ready = !w_full;
  assign o_busy1   = r_pending[i_chk_addr1];
  assign o_busy2   = r_pending[i_chk_addr2];
  assign o_we      = r_we;
  assign o_waddr   = r_waddr;
  assign o_wdata   = r_wdata;

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_l_win})
      2'b10:   w_count_d = r_count + CNT_W'(1);
      2'b01:   w_count_d = r_count - CNT_W'(1);
      default: w_count_d = r_count;
    endcase
  end

  // A P win with a non-empty FIFO implies no FORCE, so the counter is below the limit here.
  always_comb begin
    w_starve_d = '0;
    if (w_p_win && !w_empty) begin
      w_starve_d = r_starve + ST_W'(1);
    end
  end

  // Clear before set so a same-cycle issue to the retiring register keeps it pending.
  always_comb begin
    w_pending_d = r_pending;
    if (w_l_win) begin
      w_pending_d[w_head_addr] = 1'b0;
    end
    if (i_iss_valid) begin
      w_pending_d[i_iss_addr] = 1'b1;
    end
    w_pending_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= i_l_addr;
      r_fifo_data[r_wptr] <= i_l_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_starve  <= '0;
      r_pending <= '0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_l_win) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count   <= w_count_d;
      r_starve  <= w_starve_d;
      r_pending <= w_pending_d;
      r_we      <= w_write;
      if (w_write) begin
        r_waddr <= w_win_addr;
        r_wdata <= w_win_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand sequences for starvation and
// full-FIFO corners, then random traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int LIM   = 4;

  logic        i_clk, i_rst_n;
  logic        i_p_valid, i_l_valid, i_iss_valid;
  logic [4:0]  i_p_addr, i_l_addr, i_iss_addr, i_chk_addr1, i_chk_addr2;
  logic [31:0] i_p_data, i_l_data;
  logic        o_p_ready, o_l_ready, o_busy1, o_busy2, o_we;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata;

  regfile_wb_arbiter #(
    .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH), .STARVE_LIM(LIM)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_p_valid(i_p_valid), .i_p_addr(i_p_addr), .i_p_data(i_p_data), .o_p_ready(o_p_ready),
    .i_l_valid(i_l_valid), .i_l_addr(i_l_addr), .i_l_data(i_l_data), .o_l_ready(o_l_ready),
    .i_iss_valid(i_iss_valid), .i_iss_addr(i_iss_addr),
    .i_chk_addr1(i_chk_addr1), .i_chk_addr2(i_chk_addr2),
    .o_busy1(o_busy1), .o_busy2(o_busy2),
    .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue, pending as a bit vector, starvation as an int.
  typedef struct packed {logic [4:0] a; logic [31:0] d;} ent_t;
  ent_t        m_q[$];
  int          m_starve;
  logic [31:0] m_pend;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  logic        s_pr, s_lr, s_b1, s_b2, s_we;
  logic [4:0]  s_wa;
  logic [31:0] s_wd;

  task automatic m_reset();
    m_q.delete();
    m_starve = 0;
    m_pend = '0;
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
  endtask

  task automatic idle_inputs();
    i_p_valid = 1'b0; i_p_addr = '0; i_p_data = '0;
    i_l_valid = 1'b0; i_l_addr = '0; i_l_data = '0;
    i_iss_valid = 1'b0; i_iss_addr = '0;
    i_chk_addr1 = '0; i_chk_addr2 = '0;
  endtask

  // One clock: inputs already driven after a negedge; checks both comb and registered outputs.
  task automatic cycle();
    logic force_now, e_pr, e_lr, e_b1, e_b2, pwin, lwin;
    ent_t h;
    #1;
    force_now = (m_q.size() != 0) && (m_starve == LIM);
    e_pr = i_p_valid && !force_now;
    e_lr = m_q.size() < DEPTH;
    e_b1 = (i_chk_addr1 != 0) && m_pend[i_chk_addr1];
    e_b2 = (i_chk_addr2 != 0) && m_pend[i_chk_addr2];
    s_pr = o_p_ready; s_lr = o_l_ready; s_b1 = o_busy1; s_b2 = o_busy2;
    check("model p_ready", {31'd0, s_pr}, {31'd0, e_pr});
    check("model l_ready", {31'd0, s_lr}, {31'd0, e_lr});
    check("model busy1", {31'd0, s_b1}, {31'd0, e_b1});
    check("model busy2", {31'd0, s_b2}, {31'd0, e_b2});
    pwin = e_pr;
    lwin = !pwin && (m_q.size() != 0);
    @(posedge i_clk);
    m_we = 1'b0;
    if (pwin) begin
      if (i_p_addr != 0) begin m_we = 1'b1; m_wa = i_p_addr; m_wd = i_p_data; end
      if (m_q.size() != 0) m_starve = m_starve + 1;
      else m_starve = 0;
    end else begin
      m_starve = 0;
      if (lwin) begin
        h = m_q.pop_front();
        m_pend[h.a] = 1'b0;
        if (h.a != 0) begin m_we = 1'b1; m_wa = h.a; m_wd = h.d; end
      end
    end
    if (i_l_valid && e_lr) m_q.push_back('{a: i_l_addr, d: i_l_data});
    if (i_iss_valid && i_iss_addr != 0) m_pend[i_iss_addr] = 1'b1;
    #1;
    s_we = o_we; s_wa = o_waddr; s_wd = o_wdata;
    check("model we", {31'd0, s_we}, {31'd0, m_we});
    check("model waddr", {27'd0, s_wa}, {27'd0, m_wa});
    check("model wdata", s_wd, m_wd);
    @(negedge i_clk);
  endtask

  typedef struct packed {
    logic pv; logic [4:0] pa; logic [31:0] pd;
    logic lv; logic [4:0] la; logic [31:0] ld;
    logic iv; logic [4:0] ia;
    logic [4:0] c1; logic [4:0] c2;
    logic e_pr; logic e_lr; logic e_b1; logic e_b2;
    logic e_we; logic [4:0] e_wa; logic [31:0] e_wd;
  } vec_t;

  vec_t tbl [12];
  logic [4:0]  lw_addr[$];
  logic [31:0] lw_data[$];

  initial begin
    logic [31:0] pcnt;
    int          lidx;
    logic        sv_pv [10];
    logic        sv_lv [10];
    logic        sv_lr [10];
    logic        sv_pr [10];
    logic        st_pr [7];
    logic [4:0]  st_wa [7];

    // P write, issue r7, L r7 retire, L to r0, set-wins on r9, r0 query/issue ignored.
    tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5,
                1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd5,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12, 1'b0, 5'd0, 5'd7, 5'd0,
                1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0,
                1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h12};
    tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h12};
    tbl[5]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 5'd0, 5'd0,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h12};
    tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h12};
    tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd9, 5'd0,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h12};
    tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0,
                1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h99};
    tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0,
                1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h99};
    tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd9, 5'd0,
                1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h99};
    tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9,
                1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 32'h99};

    idle_inputs();
    i_rst_n = 1'b0;
    m_reset();
    #12;
    check("reset we", {31'd0, o_we}, 32'd0);
    check("reset waddr", {27'd0, o_waddr}, 32'd0);
    check("reset wdata", o_wdata, 32'd0);
    check("reset l_ready", {31'd0, o_l_ready}, 32'd1);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < 12; i++) begin
      i_p_valid = tbl[i].pv; i_p_addr = tbl[i].pa; i_p_data = tbl[i].pd;
      i_l_valid = tbl[i].lv; i_l_addr = tbl[i].la; i_l_data = tbl[i].ld;
      i_iss_valid = tbl[i].iv; i_iss_addr = tbl[i].ia;
      i_chk_addr1 = tbl[i].c1; i_chk_addr2 = tbl[i].c2;
      cycle();
      check($sformatf("row%0d p_ready", i), {31'd0, s_pr}, {31'd0, tbl[i].e_pr});
      check($sformatf("row%0d l_ready", i), {31'd0, s_lr}, {31'd0, tbl[i].e_lr});
      check($sformatf("row%0d busy1", i), {31'd0, s_b1}, {31'd0, tbl[i].e_b1});
      check($sformatf("row%0d busy2", i), {31'd0, s_b2}, {31'd0, tbl[i].e_b2});
      check($sformatf("row%0d we", i), {31'd0, s_we}, {31'd0, tbl[i].e_we});
      check($sformatf("row%0d waddr", i), {27'd0, s_wa}, {27'd0, tbl[i].e_wa});
      check($sformatf("row%0d wdata", i), s_wd, tbl[i].e_wd);
    end

    // Mid-stream async reset with r9 pending and every input active.
    i_p_valid = 1'b1; i_p_addr = 5'd6; i_p_data = 32'h66;
    i_l_valid = 1'b1; i_l_addr = 5'd10; i_l_data = 32'hAA;
    i_iss_valid = 1'b1; i_iss_addr = 5'd11;
    i_chk_addr1 = 5'd9; i_chk_addr2 = 5'd9;
    #2;
    i_rst_n = 1'b0;
    #1;
    check("midrst we", {31'd0, o_we}, 32'd0);
    check("midrst busy1", {31'd0, o_busy1}, 32'd0);
    check("midrst busy2", {31'd0, o_busy2}, 32'd0);
    check("midrst l_ready", {31'd0, o_l_ready}, 32'd1);
    m_reset();
    idle_inputs();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cycle();
    check("post-reset no write", {31'd0, s_we}, 32'd0);

    // Starvation: one L entry (r3) behind continuous P traffic to r4.
    st_pr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    st_wa = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd3, 5'd4};
    pcnt = 32'h1000;
    for (int c = 0; c < 7; c++) begin
      idle_inputs();
      i_p_valid = 1'b1; i_p_addr = 5'd4; i_p_data = pcnt;
      if (c == 0) begin i_l_valid = 1'b1; i_l_addr = 5'd3; i_l_data = 32'hA; end
      cycle();
      check($sformatf("starve%0d p_ready", c), {31'd0, s_pr}, {31'd0, st_pr[c]});
      check($sformatf("starve%0d waddr", c), {27'd0, s_wa}, {27'd0, st_wa[c]});
      check($sformatf("starve%0d wdata", c), s_wd, st_pr[c] ? pcnt : 32'hA);
      if (st_pr[c]) pcnt = pcnt + 1;
    end

    // Full FIFO: L pushes behind continuous P, then push+pop at count 3, then drain.
    sv_pv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    sv_lv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    sv_lr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    sv_pr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    lidx = 0;
    for (int c = 0; c < 20; c++) begin
      idle_inputs();
      if (c < 10) begin
        i_p_valid = sv_pv[c]; i_p_addr = 5'd4; i_p_data = pcnt;
        i_l_valid = sv_lv[c]; i_l_addr = 5'(20 + lidx); i_l_data = 32'h100 + lidx;
      end
      cycle();
      if (c < 10) begin
        check($sformatf("full%0d l_ready", c), {31'd0, s_lr}, {31'd0, sv_lr[c]});
        check($sformatf("full%0d p_ready", c), {31'd0, s_pr}, {31'd0, sv_pr[c]});
        if (sv_lv[c] && sv_lr[c]) lidx++;
        if (sv_pv[c] && sv_pr[c]) pcnt = pcnt + 1;
      end
      if (s_we && s_wa >= 5'd20) begin
        lw_addr.push_back(s_wa);
        lw_data.push_back(s_wd);
      end
    end
    check("full retired count", lw_addr.size(), 32'd7);
    for (int k = 0; k < lw_addr.size(); k++) begin
      check($sformatf("full order addr%0d", k), {27'd0, lw_addr[k]}, 32'(20 + k));
      check($sformatf("full order data%0d", k), lw_data[k], 32'h100 + k);
    end

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      i_p_valid   = ($urandom_range(0, 9) < 6);
      i_p_addr    = 5'($urandom_range(0, 31));
      i_p_data    = $urandom;
      i_l_valid   = ($urandom_range(0, 9) < 5);
      i_l_addr    = 5'($urandom_range(0, 7));
      i_l_data    = $urandom;
      i_iss_valid = ($urandom_range(0, 9) < 4);
      i_iss_addr  = 5'($urandom_range(0, 7));
      i_chk_addr1 = 5'($urandom_range(0, 7));
      i_chk_addr2 = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
